// File: rtl/ts_os_receiver.sv
// ts_os_receiver: single-lane TS1/TS2 ordered-set framer with consecutive-identical set counting.
// Define TS_OS_RX_EIOS_EN to add electrical-idle ordered set (COM IDL IDL IDL) detection.
module ts_os_receiver #(
  parameter int unsigned CONSEC_TARGET = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_k,
  input  logic             rx_err,
  input  logic             cnt_clr,
  output logic             ts_valid,
  output logic             ts_is_ts2,
  output logic [7:0]       ts_link,
  output logic             ts_link_pad,
  output logic [7:0]       ts_lane,
  output logic             ts_lane_pad,
  output logic [7:0]       ts_nfts,
  output logic [7:0]       ts_rate,
  output logic [7:0]       ts_ctrl,
  output logic             ts_bad,
  output logic [CNT_W-1:0] consec_cnt,
  output logic             consec_hit,
  output logic             eios_det
);
`ifdef TS_OS_RX_EIOS_EN
  localparam bit EIOS_EN = 1'b1;
`else
  localparam bit EIOS_EN = 1'b0;
`endif
  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] SYM_IDL = 8'h7C;
  localparam logic [7:0] ID_TS1  = 8'h4A;
  localparam logic [7:0] ID_TS2  = 8'h45;
  localparam int         KEY_W   = 35;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // state   | meaning
  // HUNT    | waiting for COM
  // COLLECT | TS symbol idx 1..15 being checked
  // EIOS    | COM IDL seen, counting IDL idx 2..3
  typedef enum logic [1:0] {HUNT, COLLECT, EIOS} state_t;

  state_t           state;
  logic [3:0]       idx;
  logic [7:0]       cur_link, cur_lane, cur_nfts, cur_rate, cur_ctrl;
  logic             cur_link_pad, cur_lane_pad, cur_ts2;
  logic             hist_vld, hist_vld_nxt;
  logic [KEY_W-1:0] hist_key, cur_key;
  logic [CNT_W-1:0] cnt_nxt;
  logic             is_com, is_pad, is_idl, chk_ok, eios_entry;
  logic             ev_good, ev_bad, ev_eios;

  assign is_com     = rx_k && (rx_data == SYM_COM);
  assign is_pad     = rx_k && (rx_data == SYM_PAD);
  assign is_idl     = rx_k && (rx_data == SYM_IDL);
  assign eios_entry = EIOS_EN && (idx == 4'd1) && is_idl;
  assign cur_key    = {cur_ts2, cur_link, cur_link_pad, cur_lane, cur_lane_pad, cur_rate, cur_ctrl};

  always_comb begin
    chk_ok = 1'b0;
    if (idx <= 4'd2)      chk_ok = !rx_k || is_pad;
    else if (idx <= 4'd5) chk_ok = !rx_k;
    else if (idx == 4'd6) chk_ok = !rx_k && ((rx_data == ID_TS1) || (rx_data == ID_TS2));
    else                  chk_ok = !rx_k && (rx_data == (cur_ts2 ? ID_TS2 : ID_TS1));
  end

  always_comb begin
    ev_good = 1'b0;
    ev_bad  = 1'b0;
    ev_eios = 1'b0;
    if (rx_valid) begin
      case (state)
        COLLECT: begin
          if (rx_err || is_com) ev_bad = 1'b1;
          else if (!eios_entry) begin
            if (!chk_ok)            ev_bad  = 1'b1;
            else if (idx == 4'd15)  ev_good = 1'b1;
          end
        end
        EIOS: begin
          if (rx_err || is_com || !is_idl) ev_bad  = 1'b1;
          else if (idx == 4'd3)            ev_eios = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A completing set always starts a fresh run when cnt_clr coincides with it.
  always_comb begin
    cnt_nxt      = consec_cnt;
    hist_vld_nxt = hist_vld;
    if (ev_good) begin
      if (hist_vld && !cnt_clr && (cur_key == hist_key))
        cnt_nxt = (consec_cnt == CNT_MAX) ? consec_cnt : consec_cnt + CNT_ONE;
      else
        cnt_nxt = CNT_ONE;
      hist_vld_nxt = 1'b1;
    end else if (ev_bad || cnt_clr) begin
      cnt_nxt      = '0;
      hist_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      idx          <= 4'd0;
      cur_link     <= 8'd0;
      cur_lane     <= 8'd0;
      cur_nfts     <= 8'd0;
      cur_rate     <= 8'd0;
      cur_ctrl     <= 8'd0;
      cur_link_pad <= 1'b0;
      cur_lane_pad <= 1'b0;
      cur_ts2      <= 1'b0;
      hist_vld     <= 1'b0;
      hist_key     <= '0;
      ts_valid     <= 1'b0;
      ts_bad       <= 1'b0;
      eios_det     <= 1'b0;
      ts_is_ts2    <= 1'b0;
      ts_link      <= 8'd0;
      ts_link_pad  <= 1'b0;
      ts_lane      <= 8'd0;
      ts_lane_pad  <= 1'b0;
      ts_nfts      <= 8'd0;
      ts_rate      <= 8'd0;
      ts_ctrl      <= 8'd0;
      consec_cnt   <= '0;
      consec_hit   <= 1'b0;
    end else begin
      ts_valid   <= ev_good;
      ts_bad     <= ev_bad;
      eios_det   <= ev_eios;
      consec_cnt <= cnt_nxt;
      consec_hit <= (32'(cnt_nxt) >= CONSEC_TARGET);
      hist_vld   <= hist_vld_nxt;
      if (ev_good) begin
        hist_key    <= cur_key;
        ts_is_ts2   <= cur_ts2;
        ts_link     <= cur_link;
        ts_link_pad <= cur_link_pad;
        ts_lane     <= cur_lane;
        ts_lane_pad <= cur_lane_pad;
        ts_nfts     <= cur_nfts;
        ts_rate     <= cur_rate;
        ts_ctrl     <= cur_ctrl;
      end
      if (rx_valid) begin
        case (state)
          HUNT: if (is_com) begin
            state <= COLLECT;
            idx   <= 4'd1;
          end
          COLLECT: begin
            if (rx_err)                        state <= HUNT;
            else if (is_com)                   idx   <= 4'd1;
            else if (eios_entry) begin
              state <= EIOS;
              idx   <= 4'd2;
            end
            else if (!chk_ok || idx == 4'd15)  state <= HUNT;
            else                               idx   <= idx + 4'd1;
            if (!rx_err && !is_com && chk_ok) begin
              case (idx)
                4'd1: begin cur_link <= rx_data; cur_link_pad <= is_pad; end
                4'd2: begin cur_lane <= rx_data; cur_lane_pad <= is_pad; end
                4'd3: cur_nfts <= rx_data;
                4'd4: cur_rate <= rx_data;
                4'd5: cur_ctrl <= rx_data;
                4'd6: cur_ts2  <= (rx_data == ID_TS2);
                default: ;
              endcase
            end
          end
          EIOS: begin
            if (rx_err) state <= HUNT;
            else if (is_com) begin
              state <= COLLECT;
              idx   <= 4'd1;
            end
            else if (!is_idl || idx == 4'd3) state <= HUNT;
            else                             idx   <= idx + 4'd1;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: doc/ts_os_receiver.md
# ts_os_receiver

Receive-side ordered-set decoder for the link training path: it consumes one 8b/10b-decoded symbol per valid cycle from a single lane and frames TS1/TS2 ordered sets. It validates each set, extracts the training fields and counts consecutive identical sets. Its outputs give the LTSSM state logic (DETECT/POLLING/CONFIGURATION/RECOVERY substates) the "N consecutive TS1/TS2 received" evidence it needs. It is the counterpart of the TS transmit path the LTSSM drives.

## Interface
- CONSEC_TARGET, 8, consecutive-identical count at which consec_hit asserts
- CNT_W, 4, width of consec_cnt; the count saturates at 2^CNT_W-1
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  rx_data/rx_k/rx_err carry a symbol this cycle
- rx_data  in  8  decoded symbol
- rx_k  in  1  symbol is a K-code
- rx_err  in  1  decode/disparity error on this symbol
- cnt_clr  in  1  LTSSM substate change; clears the consecutive history
- ts_valid  out  1  one-cycle pulse: a good TS was received
- ts_is_ts2  out  1  0 = TS1 (identifier D10.2 0x4A), 1 = TS2 (D5.2 0x45)
- ts_link  out  8  symbol 1; ts_link_pad out 1 = symbol 1 was PAD
- ts_lane  out  8  symbol 2; ts_lane_pad out 1 = symbol 2 was PAD
- ts_nfts  out  8  symbol 3
- ts_rate  out  8  symbol 4, data rate identifier
- ts_ctrl  out  8  symbol 5, training control
- ts_bad  out  1  one-cycle pulse: set aborted or malformed
- consec_cnt  out  CNT_W  current consecutive-identical count
- consec_hit  out  1  consec_cnt >= CONSEC_TARGET
- eios_det  out  1  one-cycle pulse: EIOS detected (see Configuration)

## Operation
- Symbol constants: COM is K28.5 0xBC. PAD is K23.7 0xF7. IDL is K28.3 0x7C.
- FSM states: HUNT, COLLECT (symbol index 1..15), EIOS (index 2..3; present only with the macro).
- HUNT: the FSM stays in HUNT until it receives COM (K=1) on a valid cycle, then moves to COLLECT with idx=1.
- COLLECT symbol checks:
  - idx 1 and 2: either a D-code or PAD.
  - idx 3 to 5: D-code only.
  - idx 6: a D-code equal to 0x4A or 0x45, which fixes the set type.
  - idx 7 to 15: must equal the idx-6 symbol, with K=0.
- After idx 15 passes, the set is good: ts_valid pulses and all ts_* fields load together.
- Any check failure, or rx_err on a valid cycle, in COLLECT: ts_bad pulses, consec_cnt is cleared to 0, and the FSM returns to HUNT.
- COM received at any idx in COLLECT: the partial set is dropped and ts_bad pulses. The FSM stays in COLLECT with idx=1 (resync on the new COM).
- rx_err while in HUNT is ignored.
- Consecutive compare key: {type, link, link_pad, lane, lane_pad, rate, ctrl}. N_FTS is excluded from the key.
  - Good set with key equal to the stored key and history valid: consec_cnt increments, saturating.
  - Otherwise: consec_cnt becomes 1, and the key is stored with history marked valid.
- cnt_clr: consec_cnt goes to 0 and history is invalidated.
  - cnt_clr in the same cycle a good set completes: that set is the first of a new run, so consec_cnt = 1.
  - cnt_clr in the same cycle as ts_bad: consec_cnt = 0.
- Cycles with rx_valid=0 are stalls: no state, index or counter change.

## Timing
- All outputs are registered.
- Reset value of every output is 0, FSM is in HUNT, and history is invalid.
- ts_valid, ts_bad and eios_det are asserted in the cycle after the rx_valid cycle that carried the deciding symbol. They are high for exactly one cycle.
- ts_* fields update in the same cycle as ts_valid and hold until the next ts_valid.
- consec_cnt and consec_hit update in the same cycle as ts_valid, ts_bad or the cnt_clr response.
- Back-to-back sets with no gap are accepted: a COM in the cycle after idx 15 starts the next set.
- Throughput is one symbol per cycle.
- rst_n asserted mid-set aborts the set immediately without a ts_bad pulse.

## Configuration
- TS_OS_RX_EIOS_EN defined:
  - COM followed by IDL (K=1) enters the EIOS state. Two further IDL symbols produce an eios_det pulse, and the FSM returns to HUNT. consec_cnt is not changed.
  - A non-IDL symbol or rx_err in EIOS produces ts_bad and a return to HUNT, with COM resync as in COLLECT.
- TS_OS_RX_EIOS_EN undefined:
  - eios_det is tied to 0.
  - COM followed by IDL is a malformed TS and produces ts_bad.

## Test plan
- Eight back-to-back TS1 sets with link PAD, lane PAD, nfts 0x10, rate 0x02, ctrl 0x00 -> ts_valid eight times, consec_cnt 1..8, consec_hit rising with the 8th ts_valid, ts_link_pad=1, ts_lane_pad=1.
- Six identical TS1 sets, then one TS2 with the same fields -> ts_is_ts2=1, consec_cnt=1, consec_hit=0.
- rx_err on idx 9 of the 4th set -> no ts_valid for that set, ts_bad pulse, consec_cnt=0; the next good set gives consec_cnt=1.
- COM injected at idx 7, followed by a full valid TS2 -> one ts_bad, then ts_valid with ts_is_ts2=1. Random rx_valid gaps inserted throughout -> identical results.
- cnt_clr coincident with completion of the 5th identical set -> consec_cnt=1. rst_n pulsed mid-set -> all outputs 0, no ts_bad.
- COM, IDL, IDL, IDL -> eios_det pulse with the macro defined; ts_bad pulse and eios_det=0 without it.
